// File: rtl/lfsr_burst_ctrl_pkg.sv
// Shared definitions for the LFSR burst controller: state encoding, LFSR geometry and step.
package lfsr_burst_ctrl_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned TAP_HI = 7;
    localparam int unsigned TAP_LO = 3;
    localparam logic [LFSR_W-1:0] LOCKUP_VAL = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // XNOR feedback: all-ones is the single lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
    endfunction

endpackage

// File: rtl/lfsr_burst_ctrl_lfsr8_load.sv
// 8-bit XNOR LFSR with synchronous load and step enable; load beats enable.
module lfsr8_load
    import lfsr_burst_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              enable,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (enable) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst controller: streams LFSR bytes into a FIFO write port with back-pressure and abort.
module lfsr_burst_ctrl
    import lfsr_burst_ctrl_pkg::*;
#(
    parameter int unsigned       LEN_W      = 8,
    parameter logic [LFSR_W-1:0] LOCKUP_SUB = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [LFSR_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_e             state_q;
    logic [LEN_W-1:0]   count_q;
    logic               busy_q;
    logic               done_q;
    logic               lfsr_load;
    logic [LFSR_W-1:0]  lfsr_seed;
    logic [LFSR_W-1:0]  lfsr_q;

    // Abort and back-pressure both suppress the strobe in the same cycle.
    assign wr_en     = (state_q == StRun) && !fifo_full && !abort;
    assign lfsr_load = (state_q == StIdle) && start && (length != '0);
    assign lfsr_seed = (seed == LOCKUP_VAL) ? LOCKUP_SUB : seed;

    lfsr8_load u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .enable   (wr_en),
        .q        (lfsr_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (length != '0) begin
                            state_q <= StRun;
                            count_q <= length;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (wr_en) begin
                        count_q <= count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_data = lfsr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
